// File: rtl/fifo_out_pkt.sv
// fifo_out_pkt: output FIFO with AXI-Stream master port, almost-full, sticky overflow.
// Define FIFO_OUT_PKT_MODE_EN to hold TVALID until a complete TLAST-terminated packet is stored.
module fifo_out_pkt #(
    parameter int OUTW     = 48,
    parameter int DEPTH    = 17,
    parameter int AF_SLACK = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [OUTW-1:0]            data_in,
    input  logic                       last_in,
    input  logic                       wr_en,
    output logic [$clog2(DEPTH+1)-1:0] capacity,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [OUTW-1:0]            AXIS_TDATA,
    output logic                       AXIS_TLAST,
    output logic                       AXIS_TVALID,
    input  logic                       AXIS_TREADY
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [OUTW:0]   mem [DEPTH];
    logic [OUTW:0]   rd_q;
    logic [AW-1:0]   wr_q, wr_d, tl_q, tl_d, tl_inc, raddr;
    logic [CW-1:0]   cap_q, cap_d;
    logic            ovf_q, ovf_d;
    logic            push, pop, valid;

`ifdef FIFO_OUT_PKT_MODE_EN
    logic [CW-1:0]   pkt_q, pkt_d;
    assign valid = (pkt_q != '0) || (cap_q == '0);
    always_comb begin
        pkt_d = pkt_q + CW'(push && last_in) - CW'(pop && rd_q[OUTW]);
    end
    always_ff @(posedge clk) begin
        if (reset) pkt_q <= '0;
        else       pkt_q <= pkt_d;
    end
`else
    assign valid = cap_q != CW'(DEPTH);
`endif

    always_comb begin
        pop    = valid && AXIS_TREADY;
        push   = wr_en && (cap_q != '0 || pop);
        tl_inc = (tl_q == LAST_IDX) ? '0 : tl_q + 1'b1;
        raddr  = pop ? tl_inc : tl_q;
        tl_d   = raddr;
        wr_d   = push ? ((wr_q == LAST_IDX) ? '0 : wr_q + 1'b1) : wr_q;
        cap_d  = (push && !pop) ? cap_q - 1'b1 : (pop && !push) ? cap_q + 1'b1 : cap_q;
        ovf_d  = ovf_q || (wr_en && !push);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            tl_q  <= '0;
            cap_q <= CW'(DEPTH);
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            tl_q  <= tl_d;
            cap_q <= cap_d;
            ovf_q <= ovf_d;
        end
    end

    // Look-ahead registered read; bypass covers a write landing on the slot being read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= {last_in, data_in};
        rd_q <= (push && wr_q == raddr) ? {last_in, data_in} : mem[raddr];
    end

    assign capacity    = cap_q;
    assign almost_full = cap_q <= CW'(AF_SLACK);
    assign overflow    = ovf_q;
    assign AXIS_TDATA  = rd_q[OUTW-1:0];
    assign AXIS_TLAST  = rd_q[OUTW];
    assign AXIS_TVALID = valid;
endmodule

// File: doc/fifo_out_pkt.md
Name: fifo_out_pkt

Overview:
Parametrised successor to the layer output FIFO. It buffers result words from the MAC datapath and presents them on an AXI-Stream master port, adding a TLAST sideband, an almost-full flag for upstream back-pressure, a sticky overflow flag, and write acceptance on a full-FIFO cycle when a pop frees a slot. An optional packet mode holds TVALID low until a complete TLAST-terminated packet is stored.

Parameters:
OUTW, 48, data word width in bits
DEPTH, 17, number of entries; any integer >= 2, not necessarily a power of 2
AF_SLACK, 4, almost_full asserts when capacity <= AF_SLACK; legal range 0..DEPTH

Ports:
clk  in  1  clock; single clock domain
reset  in  1  synchronous, active-high reset
data_in  in  OUTW  write data
last_in  in  1  marks data_in as the final word of a packet
wr_en  in  1  write request
capacity  out  $clog2(DEPTH+1)  number of free entries
almost_full  out  1  capacity <= AF_SLACK
overflow  out  1  sticky; a write was dropped
AXIS_TDATA  out  OUTW  head data
AXIS_TLAST  out  1  head last flag
AXIS_TVALID  out  1  head entry valid
AXIS_TREADY  in  1  downstream ready

Behaviour:
- Reset (synchronous, active-high) applies at the next edge, also mid-operation:
  - wr/tail pointers = 0, capacity = DEPTH, overflow = 0, packet count = 0.
  - Contents are discarded. TVALID = 0 in the cycle after reset is sampled.
  - almost_full = (DEPTH <= AF_SLACK).
- Storage:
  - Dual-port memory, OUTW+1 bits wide (data plus last), registered read.
  - Write-to-read bypass applies when addresses match in the same cycle.
- pop = AXIS_TVALID && AXIS_TREADY.
- push = wr_en && (capacity > 0 || pop).
  - When full, a simultaneous pop and write are both accepted and capacity stays 0.
  - DEPTH >= 2 guarantees no address conflict in this case.
- Dropped write: wr_en && !push sets overflow = 1. overflow holds until reset and the memory is unchanged.
- Pointers:
  - Each pointer increments on push or pop respectively and wraps from DEPTH-1 to 0. Wrap is explicit compare, not modulo-2^n.
- Read address is look-ahead: tail+1 (wrapped) on pop, else tail. The next head word is therefore on AXIS_TDATA/TLAST in the cycle after a pop, with no bubble.
- capacity update:
  - push && !pop: capacity - 1.
  - pop && !push: capacity + 1.
  - otherwise unchanged.
  - capacity never goes below 0 or above DEPTH.
- Latency: a word written at edge N is valid on AXIS_TDATA with TVALID = 1 in cycle N+1 when the FIFO was empty.
- TVALID is combinational from registered state (capacity, packet count); it never depends on AXIS_TREADY.
- AXI rule: once TVALID = 1, TDATA, TLAST and TVALID stay stable until pop.
- Empty with wr_en = 0: TVALID = 0 and TDATA is don't-care.
- almost_full is combinational from capacity.

Optional Feature:
Macro FIFO_OUT_PKT_MODE_EN.
- Defined: packet mode.
  - A counter pkt_cnt, width $clog2(DEPTH+1), increments on push with last_in = 1 and decrements on pop with TLAST = 1. Both in the same cycle leave it unchanged.
  - AXIS_TVALID = (pkt_cnt > 0) || (capacity == 0).
  - The capacity == 0 term is a deadlock release for packets longer than DEPTH: it streams the stored words without a packet boundary.
- Undefined:
  - AXIS_TVALID = (capacity < DEPTH).
  - last_in is stored and passed to AXIS_TLAST only; no counter logic is built.

Test Plan:
1. DEPTH=4, reset, write 0xA,0xB,0xC with TREADY=0 -> capacity 4→1, TVALID=1 one cycle after the first write, TDATA=0xA held stable; almost_full=1 (AF_SLACK=1) when capacity=1.
2. Full (capacity=0), TREADY=1 and wr_en=1 with 0xE for 1 cycle -> 0xA popped, 0xE accepted, capacity stays 0, overflow=0; subsequent pops yield 0xB,0xC,0xD,0xE back-to-back with no bubble.
3. Full, TREADY=0, wr_en=1 -> write dropped, overflow=1 and sticky, contents unchanged; reset -> overflow=0, capacity=4, TVALID=0.
4. Pointer wrap, DEPTH=5 (non-power-of-2): stream 20 words 0..19 with TREADY toggling 1010 -> output sequence 0..19 in order, no loss, no duplicates, capacity back to 5.
5. Reset asserted mid-stream with 3 words stored and TVALID=1 -> next cycle TVALID=0, capacity=DEPTH; a new word 0x55 written after reset is the first word output.
6. FIFO_OUT_PKT_MODE_EN, DEPTH=8: write 3 words, last_in on the 3rd -> TVALID stays 0 until the cycle after the 3rd write, then TLAST=1 on the 3rd pop. Write 8 words with no last -> TVALID asserts at capacity=0 (deadlock release).
